// File: rtl/gusn_pkg.sv
// Shared fixed-point definitions for the network training blocks: default widths,
// saturation helper and the loss-stage state encoding.
package gusn_pkg;

  localparam int DEF_INT_W  = 8;
  localparam int DEF_FRAC_W = 8;
  localparam int DEF_NUM_W  = DEF_INT_W + DEF_FRAC_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_CALC,
    ST_DONE
  } state_t;

  // Clamp a wide signed value into the range of a w-bit signed number; caller truncates.
  function automatic logic signed [63:0] sat_num(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/fxp_sq_sat.sv
// Combinational fixed-point difference with saturation, and its square rescaled
// by FRAC_W so the result stays in the same Q format (always non-negative).
module fxp_sq_sat
  import gusn_pkg::*;
#(
  parameter int NUM_W  = DEF_NUM_W,
  parameter int FRAC_W = DEF_FRAC_W
) (
  input  logic [NUM_W-1:0]   a,
  input  logic [NUM_W-1:0]   b,
  output logic [NUM_W-1:0]   diff_sat,
  output logic [2*NUM_W-1:0] sq
);

  logic signed [NUM_W:0]     diff;
  logic signed [2*NUM_W-1:0] prod;

  assign diff     = $signed({a[NUM_W-1], a}) - $signed({b[NUM_W-1], b});
  assign diff_sat = NUM_W'(sat_num(64'(diff), NUM_W));
  assign prod     = $signed(diff_sat) * $signed(diff_sat);
  assign sq       = prod >>> FRAC_W;

endmodule

// File: rtl/output_error.sv
// Loss stage after the last layer: per-output scaled error, saturated squared-error
// loss, and a start_b pulse that kicks off backpropagation.
//
// state   | meaning
// IDLE    | ready_out high, results held; start clears them and arms a run
// WAIT    | waiting for the upstream layer to report idle
// CALC    | one output element per cycle, idx 0..OUTPUTS-1
// DONE    | single cycle, start_b high, loss_valid set on exit
module output_error
  import gusn_pkg::*;
#(
  parameter int INT_W     = DEF_INT_W,
  parameter int FRAC_W    = DEF_FRAC_W,
  parameter int OUTPUTS   = 1,
  parameter int ERR_SHIFT = 0,
  parameter int NUM_W     = INT_W + FRAC_W
) (
  input  logic                            clk,
  input  logic                            nreset,
  input  logic                            enable,
  input  logic [OUTPUTS-1:0][NUM_W-1:0]   inputs_f,
  input  logic [OUTPUTS-1:0][NUM_W-1:0]   targets,
  input  logic                            start,
  input  logic                            ready_f_in,
  output logic [OUTPUTS-1:0][NUM_W-1:0]   errors,
  output logic [NUM_W-1:0]                loss,
  output logic                            loss_valid,
  output logic                            start_b,
  output logic                            ready_out
);

  localparam int IDX_W = (OUTPUTS > 1) ? $clog2(OUTPUTS) : 1;
  localparam int ACC_W = 2 * NUM_W + $clog2(OUTPUTS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUTPUTS - 1);

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   idx;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_nxt;
  logic [NUM_W-1:0]   cur_in;
  logic [NUM_W-1:0]   cur_tgt;
  logic [NUM_W-1:0]   diff_sat;
  logic [NUM_W-1:0]   err_scaled;
  logic [2*NUM_W-1:0] sq;
  logic               last;

  // Constant-index mux keeps the element select clean for any OUTPUTS.
  always_comb begin
    cur_in  = '0;
    cur_tgt = '0;
    for (int i = 0; i < OUTPUTS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_in  = inputs_f[i];
        cur_tgt = targets[i];
      end
    end
  end

  fxp_sq_sat #(
    .NUM_W  (NUM_W),
    .FRAC_W (FRAC_W)
  ) u_sq (
    .a        (cur_in),
    .b        (cur_tgt),
    .diff_sat (diff_sat),
    .sq       (sq)
  );

  assign err_scaled = $signed(diff_sat) >>> ERR_SHIFT;
  assign acc_nxt    = acc + ACC_W'(sq);
  assign last       = (idx == LAST_IDX);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (enable) begin
      unique case (state)
        ST_IDLE: if (start)      state_nxt = ST_WAIT;
        ST_WAIT: if (ready_f_in) state_nxt = ST_CALC;
        ST_CALC: if (last)       state_nxt = ST_DONE;
        ST_DONE:                 state_nxt = ST_IDLE;
        default:                 state_nxt = ST_IDLE;
      endcase
    end
  end

  // start_b drops while frozen so the pulse reappears once enable returns.
  assign start_b   = enable && (state == ST_DONE);
  assign ready_out = (state == ST_IDLE);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      idx        <= '0;
      acc        <= '0;
      errors     <= '0;
      loss       <= '0;
      loss_valid <= 1'b0;
    end else if (enable) begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            errors     <= '0;
            loss       <= '0;
            loss_valid <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (ready_f_in) begin
            idx <= '0;
            acc <= '0;
          end
        end
        ST_CALC: begin
          for (int i = 0; i < OUTPUTS; i++) begin
            if (idx == IDX_W'(i)) errors[i] <= err_scaled;
          end
          acc <= acc_nxt;
          if (last) loss <= NUM_W'(sat_num(64'(acc_nxt), NUM_W));
          else      idx  <= idx + 1'b1;
        end
        ST_DONE: loss_valid <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_output_error.sv
// Scoreboard bench for output_error: three instances (two-output, one-output,
// one-output with error shift); expectations queued at start, checked on start_b.
module tb_output_error;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] err;
    logic [15:0] loss;
  } exp_t;

  exp_t exp_a[$];
  exp_t exp_b[$];
  exp_t exp_c[$];
  exp_t ea, eb, ec;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // DUT A: OUTPUTS=2
  logic                rst_a, en_a, go_a, rdy_a;
  logic [1:0][15:0]    in_a, tgt_a, err_a;
  logic [15:0]         loss_a;
  logic                lv_a, sb_a, ro_a;

  output_error #(.INT_W(8), .FRAC_W(8), .OUTPUTS(2), .ERR_SHIFT(0)) dut_a (
    .clk(clk), .nreset(rst_a), .enable(en_a), .inputs_f(in_a), .targets(tgt_a),
    .start(go_a), .ready_f_in(rdy_a), .errors(err_a), .loss(loss_a),
    .loss_valid(lv_a), .start_b(sb_a), .ready_out(ro_a));

  // DUT B: OUTPUTS=1 ; DUT C: OUTPUTS=1, ERR_SHIFT=2
  logic                rst_n, go_bc;
  logic [0:0][15:0]    in_b, tgt_b, err_b, in_c, tgt_c, err_c;
  logic [15:0]         loss_b, loss_c;
  logic                lv_b, sb_b, ro_b, lv_c, sb_c, ro_c;

  output_error #(.INT_W(8), .FRAC_W(8), .OUTPUTS(1), .ERR_SHIFT(0)) dut_b (
    .clk(clk), .nreset(rst_n), .enable(1'b1), .inputs_f(in_b), .targets(tgt_b),
    .start(go_bc), .ready_f_in(1'b1), .errors(err_b), .loss(loss_b),
    .loss_valid(lv_b), .start_b(sb_b), .ready_out(ro_b));

  output_error #(.INT_W(8), .FRAC_W(8), .OUTPUTS(1), .ERR_SHIFT(2)) dut_c (
    .clk(clk), .nreset(rst_n), .enable(1'b1), .inputs_f(in_c), .targets(tgt_c),
    .start(go_bc), .ready_f_in(1'b1), .errors(err_c), .loss(loss_c),
    .loss_valid(lv_c), .start_b(sb_c), .ready_out(ro_c));

  // Monitors
  always @(negedge clk) begin
    if (sb_a === 1'b1) begin
      if (exp_a.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL a_start_b: unexpected pulse, got 1 required 0");
      end else begin
        ea = exp_a.pop_front();
        chk("a_errors", 64'(err_a), 64'(ea.err));
        chk("a_loss", 64'(loss_a), 64'(ea.loss));
      end
    end
    if (sb_b === 1'b1) begin
      if (exp_b.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL b_start_b: unexpected pulse, got 1 required 0");
      end else begin
        eb = exp_b.pop_front();
        chk("b_errors", 64'(err_b), 64'(eb.err));
        chk("b_loss", 64'(loss_b), 64'(eb.loss));
      end
    end
    if (sb_c === 1'b1) begin
      if (exp_c.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL c_start_b: unexpected pulse, got 1 required 0");
      end else begin
        ec = exp_c.pop_front();
        chk("c_errors", 64'(err_c), 64'(ec.err));
        chk("c_loss", 64'(loss_c), 64'(ec.loss));
      end
    end
  end

  // Count negedges until start_b on A, bounded.
  task automatic wait_sb_a(input string name, input int req);
    int n = 0;
    while (sb_a !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(n), 64'(req));
  endtask

  task automatic start_a_pulse();
    go_a = 1'b1;
    @(negedge clk);
    go_a = 1'b0;
  endtask

  task automatic load_test1();
    in_a  = {16'h0100, 16'h0300};
    tgt_a = {16'h0100, 16'h0100};
  endtask

  initial begin
    int n;
    rst_a = 1'b0; rst_n = 1'b0; en_a = 1'b1; go_a = 1'b0; rdy_a = 1'b0; go_bc = 1'b0;
    in_a = '0; tgt_a = '0; in_b = '0; tgt_b = '0; in_c = '0; tgt_c = '0;
    repeat (2) @(negedge clk);
    chk("rst_errors", 64'(err_a), 64'h0);
    chk("rst_loss", 64'(loss_a), 64'h0);
    chk("rst_loss_valid", 64'(lv_a), 64'h0);
    chk("rst_start_b", 64'(sb_a), 64'h0);
    chk("rst_ready_out", 64'(ro_a), 64'h1);
    rst_a = 1'b1; rst_n = 1'b1;
    @(negedge clk);

    // 1: basic two-element run
    load_test1(); rdy_a = 1'b1;
    exp_a.push_back('{err: {16'h0000, 16'h0200}, loss: 16'h0400});
    start_a_pulse();
    chk("t1_ready_out_low", 64'(ro_a), 64'h0);
    wait_sb_a("t1_latency", 3);
    @(negedge clk);
    chk("t1_loss_valid", 64'(lv_a), 64'h1);
    chk("t1_ready_out_high", 64'(ro_a), 64'h1);
    chk("t1_errors_held", 64'(err_a), 64'h0000_0200);

    // 2 and 3: saturation and shifted error on the single-output instances
    in_b = 16'h7F00; tgt_b = 16'h8000;
    in_c = 16'hFC00; tgt_c = 16'h0000;
    exp_b.push_back('{err: 32'h0000_7FFF, loss: 16'h7FFF});
    exp_c.push_back('{err: 32'h0000_FF00, loss: 16'h1000});
    go_bc = 1'b1;
    @(negedge clk);
    go_bc = 1'b0;
    n = 0;
    while (sb_b !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t2_latency", 64'(n), 64'd2);
    @(negedge clk);
    chk("t2_loss_valid", 64'(lv_b), 64'h1);
    chk("t3_loss_valid", 64'(lv_c), 64'h1);
    chk("t3_errors_held", 64'(err_c), 64'hFF00);

    // 4: upstream busy for 5 cycles; start during WAIT ignored
    rdy_a = 1'b0;
    in_a  = {16'h0080, 16'hFF00};
    tgt_a = {16'hFF80, 16'h0100};
    exp_a.push_back('{err: {16'h0100, 16'hFE00}, loss: 16'h0500});
    start_a_pulse();
    go_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t4_wait_ready_out", 64'(ro_a), 64'h0);
      @(negedge clk);
    end
    go_a = 1'b0;
    chk("t4_cleared_loss_valid", 64'(lv_a), 64'h0);
    rdy_a = 1'b1;
    wait_sb_a("t4_latency", 3);
    @(negedge clk);

    // 5: freeze mid-CALC, start during CALC ignored
    load_test1();
    exp_a.push_back('{err: {16'h0000, 16'h0200}, loss: 16'h0400});
    start_a_pulse();              // now WAIT
    @(negedge clk);               // CALC idx0 pending
    @(negedge clk);               // idx0 done, idx1 pending
    en_a = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_frozen_err0", 64'(err_a), 64'h0000_0200);
    chk("t5_frozen_ready_out", 64'(ro_a), 64'h0);
    en_a = 1'b1; go_a = 1'b1;
    @(negedge clk);
    go_a = 1'b0;
    wait_sb_a("t5_latency", 0);
    repeat (4) @(negedge clk);
    chk("t5_no_second_run", 64'(ro_a), 64'h1);

    // 5b: enable low during DONE suppresses then re-issues start_b
    exp_a.push_back('{err: {16'h0000, 16'h0200}, loss: 16'h0400});
    go_a = 1'b1;
    @(posedge clk); #1 go_a = 1'b0;
    repeat (3) @(posedge clk);
    #1 en_a = 1'b0;
    @(negedge clk);
    chk("t5b_start_b_frozen", 64'(sb_a), 64'h0);
    @(negedge clk);
    chk("t5b_start_b_frozen2", 64'(sb_a), 64'h0);
    @(posedge clk); #1 en_a = 1'b1;
    @(negedge clk);
    chk("t5b_start_b_reissued", 64'(sb_a), 64'h1);
    @(negedge clk);
    chk("t5b_single_pulse", 64'(sb_a), 64'h0);

    // 6: async reset mid-CALC, then a clean run
    load_test1();
    start_a_pulse();
    @(negedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    #1;
    chk("t6_rst_errors", 64'(err_a), 64'h0);
    chk("t6_rst_loss", 64'(loss_a), 64'h0);
    chk("t6_rst_loss_valid", 64'(lv_a), 64'h0);
    chk("t6_rst_start_b", 64'(sb_a), 64'h0);
    chk("t6_rst_ready_out", 64'(ro_a), 64'h1);
    @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    exp_a.push_back('{err: {16'h0000, 16'h0200}, loss: 16'h0400});
    start_a_pulse();
    wait_sb_a("t6_latency", 3);

    repeat (3) @(negedge clk);
    chk("a_queue_drained", 64'(exp_a.size()), 64'h0);
    chk("b_queue_drained", 64'(exp_b.size()), 64'h0);
    chk("c_queue_drained", 64'(exp_c.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, got timeout required finish");
    $fatal(1, "timeout");
  end

endmodule
